// File: rtl/countdown_timer.sv
// Prescaled down-counter with pause/resume, optional auto-reload and a sticky terminal-count irq.
// tick, tc_pulse and busy are decoded directly from the state registers.
module countdown_timer #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned PRE_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [PRE_W-1:0] prescale,
    input  logic             auto_reload,
    input  logic             irq_clr,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc_pulse,
    output logic             irq,
    output logic             busy,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic [PRE_W-1:0] r_pre_cnt;
    logic             r_irq;

    logic             w_tick;
    logic             w_tc;
    logic             w_go;

    assign w_tick = (r_state == RUN) && (r_pre_cnt == '0);
    assign w_tc   = w_tick && (r_count == '0);
    // stop outranks start whenever both are requested
    assign w_go   = start && !stop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_count   <= '1;
            r_reload  <= '1;
            r_pre_cnt <= '0;
            r_irq     <= 1'b0;
        end else begin
            if (w_tc) begin
                r_irq <= 1'b1;
            end else if (irq_clr) begin
                r_irq <= 1'b0;
            end

            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_reload  <= load_val;
                        r_count   <= load_val;
                        r_pre_cnt <= prescale;
                    end
                    if (w_go) begin
                        r_state   <= RUN;
                        r_pre_cnt <= prescale;
                    end
                end

                RUN: begin
                    if (load) begin
                        r_reload <= load_val;
                    end
                    if (stop) begin
                        r_state <= PAUSE;
                    end else if (w_tick) begin
                        // prescale is only sampled here, at the reload point
                        r_pre_cnt <= prescale;
                        if (r_count != '0) begin
                            r_count <= r_count - WIDTH'(1);
                        end else if (auto_reload) begin
                            r_count <= r_reload;
                        end else begin
                            r_state <= DONE;
                        end
                    end else begin
                        r_pre_cnt <= r_pre_cnt - PRE_W'(1);
                    end
                end

                PAUSE: begin
                    if (load) begin
                        r_reload  <= load_val;
                        r_count   <= load_val;
                        r_pre_cnt <= prescale;
                    end
                    if (stop) begin
                        r_state <= IDLE;
                    end else if (start) begin
                        r_state <= RUN;
                    end
                end

                DONE: begin
                    if (load) begin
                        r_reload  <= load_val;
                        r_count   <= load_val;
                        r_pre_cnt <= prescale;
                        r_state   <= IDLE;
                    end
                    if (w_go) begin
                        r_state   <= RUN;
                        r_count   <= load ? load_val : r_reload;
                        r_pre_cnt <= prescale;
                    end
                end

                default: r_state <= IDLE;
            endcase
        end
    end

    assign count    = r_count;
    assign state    = r_state;
    assign irq      = r_irq;
    assign tick     = w_tick;
    assign tc_pulse = w_tc;
    assign busy     = (r_state == RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: per-cycle expectations are queued as stimulus is
// driven and compared against the DUT outputs on the following falling edge.
module tb_countdown_timer;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned PRE_W = 8;

    localparam logic [1:0] S_IDLE  = 2'b00;
    localparam logic [1:0] S_RUN   = 2'b01;
    localparam logic [1:0] S_PAUSE = 2'b10;
    localparam logic [1:0] S_DONE  = 2'b11;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             stop;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [PRE_W-1:0] prescale;
    logic             auto_reload;
    logic             irq_clr;
    logic [WIDTH-1:0] count;
    logic             tick;
    logic             tc_pulse;
    logic             irq;
    logic             busy;
    logic [1:0]       state;

    typedef struct {
        string      tag;
        logic [9:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    countdown_timer #(.WIDTH(WIDTH), .PRE_W(PRE_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .stop        (stop),
        .load        (load),
        .load_val    (load_val),
        .prescale    (prescale),
        .auto_reload (auto_reload),
        .irq_clr     (irq_clr),
        .count       (count),
        .tick        (tick),
        .tc_pulse    (tc_pulse),
        .irq         (irq),
        .busy        (busy),
        .state       (state)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] pk(input logic [3:0] c, input logic [1:0] s,
                                      input logic tk, input logic tc,
                                      input logic iq, input logic bz);
        return {c, s, tk, tc, iq, bz};
    endfunction

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] expv);
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL %s: got cnt=%h st=%b tick=%b tc=%b irq=%b busy=%b, expected cnt=%h st=%b tick=%b tc=%b irq=%b busy=%b",
                     tag, got[9:6], got[5:4], got[3], got[2], got[1], got[0],
                     expv[9:6], expv[5:4], expv[3], expv[2], expv[1], expv[0]);
        end
    endtask

    // Queue the expectation for the current cycle, then advance one clock.
    task automatic step(input string tag, input logic [9:0] e);
        exp_t x;
        x.tag = tag;
        x.val = e;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            check(x.tag, pk(count, state, tick, tc_pulse, irq, busy), x.val);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [3:0] c;
        reset = 1'b1; start = 1'b0; stop = 1'b0; load = 1'b0; load_val = '0;
        prescale = '0; auto_reload = 1'b0; irq_clr = 1'b0;

        // reset state and free-running countdown with prescale=0
        @(posedge clk); #1;
        step("reset_state", pk(4'hF, S_IDLE, 0, 0, 0, 0));
        reset = 1'b0;
        step("idle_after_reset", pk(4'hF, S_IDLE, 0, 0, 0, 0));
        start = 1'b1;
        step("idle_start", pk(4'hF, S_IDLE, 0, 0, 0, 0));
        start = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            step("count_down", pk(4'(i), S_RUN, 1, (i == 0), 0, 1));
        end
        step("done_state", pk(4'h0, S_DONE, 0, 0, 1, 0));

        // load 3 with prescale 2, auto-reload; clear irq in the same cycle as the load
        load = 1'b1; load_val = 4'd3; prescale = 8'd2; auto_reload = 1'b1; irq_clr = 1'b1;
        step("done_load", pk(4'h0, S_DONE, 0, 0, 1, 0));
        load = 1'b0; irq_clr = 1'b0; start = 1'b1;
        step("idle_loaded", pk(4'h3, S_IDLE, 0, 0, 0, 0));
        start = 1'b0;

        for (int k = 0; k <= 43; k++) begin
            logic tk, tc, iq;
            tk = (k % 3 == 2);
            tc = (k == 11) || (k == 23) || (k == 35);
            iq = (k >= 12) && (k <= 36);
            if (k < 36) c = 4'(3 - ((k / 3) % 4));
            else        c = 4'(7 - ((k - 36) / 3));
            load     = (k == 24);
            load_val = (k == 24) ? 4'd7 : 4'd0;
            irq_clr  = (k == 35) || (k == 36);
            stop     = (k == 43);
            step("auto_reload_run", pk(c, S_RUN, tk, tc, iq, 1));
        end
        load = 1'b0; irq_clr = 1'b0; stop = 1'b0;

        // paused for a while, then resume with the same prescaler phase
        for (int i = 0; i < 10; i++) begin
            step("pause_hold", pk(4'h5, S_PAUSE, 0, 0, 0, 0));
        end
        start = 1'b1;
        step("pause_resume", pk(4'h5, S_PAUSE, 0, 0, 0, 0));
        start = 1'b0;
        step("resume_p0", pk(4'h5, S_RUN, 0, 0, 0, 1));
        step("resume_p1", pk(4'h5, S_RUN, 1, 0, 0, 1));
        stop = 1'b1;
        step("resume_p2", pk(4'h4, S_RUN, 0, 0, 0, 1));

        // start+stop together in PAUSE aborts to IDLE keeping count
        start = 1'b1;
        step("pause_again", pk(4'h4, S_PAUSE, 0, 0, 0, 0));
        stop = 1'b0;
        step("abort_idle", pk(4'h4, S_IDLE, 0, 0, 0, 0));
        start = 1'b0;
        step("restart_run", pk(4'h4, S_RUN, 0, 0, 0, 1));

        // asynchronous reset in the middle of RUN
        reset = 1'b1;
        #2;
        check("async_reset", pk(count, state, tick, tc_pulse, irq, busy),
              pk(4'hF, S_IDLE, 0, 0, 0, 0));
        step("reset_hold", pk(4'hF, S_IDLE, 0, 0, 0, 0));
        reset = 1'b0;
        step("post_reset", pk(4'hF, S_IDLE, 0, 0, 0, 0));

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            check("queue_drain", 10'(exp_q.size()), 10'd0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
